mux41h_rr_arb: RTL and testbench
================================

// Module: mux41h_rr_arb
// PURPOSE
//   Round-robin arbiter/sequencer sharing one WIDTH-bit 4:1 one-hot mux among four requesters (a..d).
//   Drives the mux's one-hot select, registers the selected word into an output stage with a
//   valid/ready handshake, and returns a per-beat grant to the winning requester.
//   Sits between operand sources and a single shared arithmetic datapath input.
// PARAMETERS
//   WIDTH     11  data width of each source and of out
//   MAXBURST  4   max consecutive beats per grant before forced hand-off (>=1; 1 = pure round-robin)
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous, active-low reset
//   req        in   4      req[i] = requester i has a word pending; held until gnt[i]
//   a,b,c,d    in   WIDTH  source words of requesters 0..3; stable while req[i] && !gnt[i]
//   sel        out  4      registered one-hot mux select (0000 = none), owner's bit
//   gnt        out  4      one-hot, 1-cycle pulse: owner's word captured into out this cycle
//   out        out  WIDTH  registered output word
//   out_valid  out  1      out holds an unconsumed word
//   out_ready  in   1      downstream accepts out when out_valid && out_ready
// BEHAVIOUR
//   Reset (async, reset_n=0): sel=0000, gnt=0000, out=0, out_valid=0, state=IDLE, burst cnt=0,
//     last_owner=3 (so requester 0 wins first). All take effect immediately, not at a clock edge.
//   States: IDLE (sel=0000), GRANT (sel=onehot(owner)).
//   next(p) = first asserted req in order p+1,p+2,p+3,p (mod 4); none -> no winner.
//   IDLE: if |req, sel<=onehot(next(last_owner)), owner<=winner, cnt<=0, ->GRANT (1-cycle latency req->sel).
//   GRANT, space = !out_valid || out_ready; beat = req[owner] && space:
//     - beat: gnt[owner]=1 (combinational from registered state), out<=mux(sel) next edge,
//       out_valid<=1, cnt<=cnt+1.
//     - !beat && out_valid && out_ready: out_valid<=0.
//     - release = !req[owner] || (beat && cnt==MAXBURST-1).
//       On release: last_owner<=owner; if next(owner) exists -> sel/owner<=next, cnt<=0, stay GRANT
//       (no bubble on burst-limit hand-off; one idle cycle when owner drops req); else ->IDLE, sel<=0.
//   Backpressure: out_valid && !out_ready -> no beat, gnt=0, out/cnt/owner hold; req[owner] must stay high.
//   Owner may drop req only when no word pending; drop releases that cycle with no beat.
//   Invariants: sel and gnt are one-hot or zero, never multi-hot; gnt[i] implies sel[i].
//   Throughput: one word per cycle while out_ready=1; data latency gnt -> out_valid = 1 cycle.
//   Widths: cnt is $clog2(MAXBURST+1) bits, compare against MAXBURST-1 at that width.
// STRUCTURE
//   Shared package: state encoding (ST_IDLE, ST_GRANT), 2-bit requester index type, onehot4()
//     and rr_next() functions.
//   One sub-module: existing mux41hx11 (WIDTH=11) instantiated on sel to form the mux output;
//     arbiter FSM, burst counter and output register live in this module.
// TESTING
//   1 Reset: reset_n=0 with req=1111 -> sel=0000, gnt=0000, out=0, out_valid=0 throughout.
//   2 Solo: req=0100, c=11'h155, out_ready=1 -> sel=0100 after 1 cycle; gnt[2] every cycle;
//     out=11'h155, out_valid=1 from next cycle; forced re-grant to 2 every 4 beats, no bubbles.
//   3 Fairness: req=1111 held, out_ready=1, a..d=11'h001/002/004/008 -> out sequence 4x001, 4x002,
//     4x004, 4x008, then 4x001; no gaps at hand-off.
//   4 Backpressure: solo req[1], out_ready=0 for 3 cycles after beat 2 -> gnt=0000, out and cnt hold;
//     on out_ready=1 beats 3,4 complete, then hand-off.
//   5 Drop: owner 0 drops req after 2 beats, req[3]=1 -> 1 cycle with gnt=0000, then sel=1000, gnt[3].
//   6 Async reset mid-burst between edges -> outputs clear immediately; after release with req=1111,
//     first gnt is 0001.

Source files
------------

// File: rtl/mux41h_rr_arb_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter.
//   ST_IDLE / ST_GRANT : FSM state encoding
//   req_idx_t          : 2-bit requester index (0..3 = a..d)
//   rr_pick_t          : result of a round-robin search (found flag + index)
//   onehot4()          : index -> one-hot select
//   rr_next()          : first asserted request after a given index, wrapping back to that index last
package mux41h_rr_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  typedef logic [1:0] req_idx_t;

  typedef struct packed {
    logic     found;
    req_idx_t idx;
  } rr_pick_t;

  function automatic logic [3:0] onehot4(input req_idx_t idx);
    return 4'b0001 << idx;
  endfunction

  // Search order p+1, p+2, p+3, p so the previous owner is only picked
  // again when nobody else is asking.
  function automatic rr_pick_t rr_next(input req_idx_t p, input logic [3:0] req);
    rr_pick_t r;
    req_idx_t cand;
    r.found = 1'b0;
    r.idx   = p;
    for (int k = 1; k <= 4; k++) begin
      cand = p + req_idx_t'(k);
      if (!r.found && req[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux41h_rr_arb_mux.sv
// One-hot 4:1 word mux (AND-OR structure, zero output when sel is 0000).
//   sel      in  4      one-hot select, bit i picks source i
//   a,b,c,d  in  WIDTH  source words 0..3
//   out      out WIDTH  selected word
module mux41hx11 #(
  parameter int WIDTH = 11
) (
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out
);

  assign out = ({WIDTH{sel[0]}} & a) |
               ({WIDTH{sel[1]}} & b) |
               ({WIDTH{sel[2]}} & c) |
               ({WIDTH{sel[3]}} & d);

endmodule

// File: rtl/mux41h_rr_arb.sv
// Round-robin arbiter sharing one one-hot 4:1 mux among four requesters.
// Drives the registered mux select, captures the selected word into an
// output register with valid/ready handshake and pulses a per-beat grant.
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   req        in   4      pending word per requester, held until granted
//   a,b,c,d    in   WIDTH  source words of requesters 0..3
//   sel        out  4      registered one-hot select of current owner (0000 = none)
//   gnt        out  4      one-hot pulse: owner's word is captured this cycle
//   out        out  WIDTH  registered output word
//   out_valid  out  1      out holds an unconsumed word
//   out_ready  in   1      downstream accepts out when out_valid && out_ready
//
// state    | meaning
// ST_IDLE  | no owner, sel = 0000, waiting for any request
// ST_GRANT | owner holds the mux, sel = onehot(owner), beats while space
module mux41h_rr_arb
  import mux41h_rr_arb_pkg::*;
#(
  parameter int WIDTH    = 11,
  parameter int MAXBURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       sel,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int             CW       = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MAXBURST - 1);

  logic [0:0]       state;
  req_idx_t         owner;
  req_idx_t         last_owner;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mux_out;

  rr_pick_t pick_idle;
  rr_pick_t pick_hand;
  logic     is_grant;
  logic     space;
  logic     beat;
  logic     rel;

  mux41hx11 #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .out (mux_out)
  );

  assign pick_idle = rr_next(last_owner, req);
  assign pick_hand = rr_next(owner, req);

  assign is_grant = (state == ST_GRANT);
  assign space    = !out_valid || out_ready;
  assign beat     = is_grant && req[owner] && space;
  // Owner dropping req releases with no beat; hitting the burst limit
  // releases on the last beat so the hand-off costs no bubble.
  assign rel      = is_grant && (!req[owner] || (beat && (cnt == CNT_LAST)));

  assign gnt = beat ? onehot4(owner) : 4'b0000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sel        <= 4'b0000;
      out        <= '0;
      out_valid  <= 1'b0;
      cnt        <= '0;
      owner      <= 2'd0;
      last_owner <= 2'd3;
    end else begin
      if (beat) begin
        out       <= mux_out;
        out_valid <= 1'b1;
        cnt       <= cnt + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pick_idle.found) begin
            owner <= pick_idle.idx;
            sel   <= onehot4(pick_idle.idx);
            cnt   <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            last_owner <= owner;
            // A burst-limited owner still requesting may win again here
            // when no one else is waiting; cnt restart overrides the beat increment.
            if (pick_hand.found) begin
              owner <= pick_hand.idx;
              sel   <= onehot4(pick_hand.idx);
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
              sel   <= 4'b0000;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          sel   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux41h_rr_arb.sv
module tb_mux41h_rr_arb;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [10:0] a, b, c, d;
  logic [3:0]  sel;
  logic [3:0]  gnt;
  logic [10:0] out;
  logic        out_valid;
  logic        out_ready;

  int n_checks;
  int n_errors;

  mux41h_rr_arb #(.WIDTH(11), .MAXBURST(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .sel       (sel),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    req       = 4'b1111;
    a         = 11'h0A1;
    b         = 11'h0B2;
    c         = 11'h0C3;
    d         = 11'h0D4;
    out_ready = 1'b1;

    // 1 reset held with all requests active
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_sel",   32'(sel),       32'h0);
      chk("rst_gnt",   32'(gnt),       32'h0);
      chk("rst_out",   32'(out),       32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
    end

    // 2 solo requester 2, continuous beats across forced re-grants
    reset_n = 1'b1;
    req     = 4'b0100;
    c       = 11'h155;
    #1;
    chk("solo_gnt_idle", 32'(gnt), 32'h0);
    tick();
    chk("solo_sel",  32'(sel),  32'h4);
    chk("solo_gnt0", 32'(gnt),  32'h4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("solo_gnt",   32'(gnt),       32'h4);
      chk("solo_selh",  32'(sel),       32'h4);
      chk("solo_out",   32'(out),       32'h155);
      chk("solo_valid", 32'(out_valid), 32'h1);
    end
    req = 4'b0000;
    #1;
    chk("solo_drop_gnt", 32'(gnt), 32'h0);
    tick();
    chk("solo_idle_sel",   32'(sel),       32'h0);
    chk("solo_idle_valid", 32'(out_valid), 32'h0);

    // 3 fairness with all four requesting
    do_reset();
    req = 4'b1111;
    a   = 11'h001;
    b   = 11'h002;
    c   = 11'h004;
    d   = 11'h008;
    tick();
    chk("fair_sel0", 32'(sel), 32'h1);
    chk("fair_gnt0", 32'(gnt), 32'h1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("fair_out",   32'(out),       32'(1) << ((k / 4) % 4));
      chk("fair_valid", 32'(out_valid), 32'h1);
      chk("fair_sel",   32'(sel),       32'(1) << (((k + 1) / 4) % 4));
      chk("fair_gnt",   32'(gnt),       32'(1) << (((k + 1) / 4) % 4));
    end
    req = 4'b0000;
    tick();
    tick();

    // 4 backpressure on requester 1, then hand-off to 3
    do_reset();
    req = 4'b0010;
    b   = 11'h101;
    d   = 11'h0AB;
    tick();
    chk("bp_sel", 32'(sel), 32'h2);
    tick();
    chk("bp_out1", 32'(out), 32'h101);
    b = 11'h102;
    tick();
    chk("bp_out2", 32'(out), 32'h102);
    b         = 11'h103;
    req       = 4'b1010;
    out_ready = 1'b0;
    #1;
    chk("bp_gnt_stall", 32'(gnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_gnt",   32'(gnt),       32'h0);
      chk("bp_hold_out",   32'(out),       32'h102);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_hold_sel",   32'(sel),       32'h2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_gnt_resume", 32'(gnt), 32'h2);
    tick();
    chk("bp_out3",   32'(out), 32'h103);
    chk("bp_sel3",   32'(sel), 32'h2);
    chk("bp_gnt4",   32'(gnt), 32'h2);
    b = 11'h104;
    tick();
    chk("bp_out4",    32'(out), 32'h104);
    chk("bp_hand_sel", 32'(sel), 32'h8);
    chk("bp_hand_gnt", 32'(gnt), 32'h8);
    req = 4'b1000;
    tick();
    chk("bp_out_d", 32'(out), 32'h0AB);
    req = 4'b0000;
    tick();
    tick();

    // 5 owner 0 drops after two beats while 3 waits
    do_reset();
    req = 4'b1001;
    a   = 11'h0A1;
    d   = 11'h0D4;
    tick();
    chk("drop_sel0", 32'(sel), 32'h1);
    tick();
    chk("drop_out1", 32'(out), 32'h0A1);
    tick();
    chk("drop_out2", 32'(out), 32'h0A1);
    req = 4'b1000;
    #1;
    chk("drop_gnt_gap",   32'(gnt),       32'h0);
    chk("drop_sel_gap",   32'(sel),       32'h1);
    chk("drop_valid_gap", 32'(out_valid), 32'h1);
    tick();
    chk("drop_sel3",   32'(sel),       32'h8);
    chk("drop_gnt3",   32'(gnt),       32'h8);
    chk("drop_valid0", 32'(out_valid), 32'h0);
    tick();
    chk("drop_out_d",  32'(out),       32'h0D4);
    chk("drop_valid1", 32'(out_valid), 32'h1);

    // 6 async reset mid-burst, between clock edges
    req = 4'b1111;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_sel",   32'(sel),       32'h0);
    chk("arst_gnt",   32'(gnt),       32'h0);
    chk("arst_out",   32'(out),       32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    tick();
    chk("arst_hold_sel", 32'(sel), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("arst_first_sel", 32'(sel), 32'h1);
    chk("arst_first_gnt", 32'(gnt), 32'h1);
    tick();
    chk("arst_first_out", 32'(out),       32'h0A1);
    chk("arst_valid1",    32'(out_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
